// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : arbiter FSM encoding
//   memop_t     : 3-bit MemOp code, carried through untouched
//   port_idx_t  : index of a requesting master
package dmem_arb_pkg;

    localparam int ARB_NPORTS = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RDWAIT = 2'd2
    } arb_state_t;

    typedef logic [2:0] memop_t;

    typedef logic [$clog2(ARB_NPORTS)-1:0] port_idx_t;

endpackage

// File: rtl/rr_pick2.sv
// Two-way winner select for the data-memory arbiter.
// Build option: DMEM_ARB_RR_EN defined -> round-robin with a last-served
// pointer; undefined -> fixed priority, port 0 always wins, no pointer.
// Ports:
//   clock, reset_n : system clock, async active-low reset (pointer only)
//   req0, req1     : live request lines
//   take           : a grant is being made this cycle, advance pointer
//   winner         : selected port (valid when any_req)
//   any_req        : at least one request present
module rr_pick2
    import dmem_arb_pkg::*;
(
    input  logic      clock,
    input  logic      reset_n,
    input  logic      req0,
    input  logic      req1,
    input  logic      take,
    output port_idx_t winner,
    output logic      any_req
);

    assign any_req = req0 | req1;

`ifdef DMEM_ARB_RR_EN
    port_idx_t last;

    // Reset to "port 1 served last" so the first contention goes to port 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            last <= port_idx_t'(1);
        else if (take)
            last <= winner;
    end

    always_comb begin
        if (req0 && req1)
            winner = ~last;
        else if (req1)
            winner = port_idx_t'(1);
        else
            winner = port_idx_t'(0);
    end
`else
    logic unused_rr;
    assign unused_rr = &{1'b0, clock, reset_n, take};

    assign winner = (req1 && !req0) ? port_idx_t'(1) : port_idx_t'(0);
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data_mem port between the CPU load/store path (port 0)
// and a second bus master (port 1). One request is latched at a time; read
// data comes back on the shared rdata bus with a per-port rvalid pulse.
// Build option: DMEM_ARB_RR_EN selects round-robin arbitration (see rr_pick2);
// without it port 0 has fixed priority.
// Ports:
//   clock, reset_n            : system clock, async active-low reset
//   reqN/weN/addrN/wdataN/memopN : master N request and payload
//   gntN                      : one-cycle pulse, request issued to memory
//   rvalidN, rdata            : read result for master N
//   mem_addr/mem_wdata/mem_memop/mem_we : drive data_mem
//   mem_rdata                 : data_mem read data
//
// state      | meaning
// ARB_IDLE   | sample requests, latch winner payload
// ARB_ACCESS | payload on memory bus, gnt to winner, write strobe
// ARB_RDWAIT | count down read latency, capture rdata at zero
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  memop_t            memop0,
    input  memop_t            memop1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output memop_t            mem_memop,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state, next_state;
    port_idx_t  win, sel;
    logic       any_req, take, we_q;
    logic [1:0] cnt;

    assign take = (state == ARB_IDLE) && any_req;

    rr_pick2 u_pick (
        .clock   (clock),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .take    (take),
        .winner  (win),
        .any_req (any_req)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= ARB_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ARB_IDLE:   if (any_req) next_state = ARB_ACCESS;
            ARB_ACCESS: next_state = we_q ? ARB_IDLE : ARB_RDWAIT;
            ARB_RDWAIT: if (cnt == 2'd0) next_state = ARB_IDLE;
            default:    next_state = ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        mem_we = 1'b0;
        if (state == ARB_ACCESS) begin
            gnt0   = (sel == port_idx_t'(0));
            gnt1   = (sel == port_idx_t'(1));
            mem_we = we_q;
        end
    end

    // Payload stays on the memory bus through RDWAIT so a pipelined
    // memory keeps seeing a stable address.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel       <= port_idx_t'(0);
            we_q      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_memop <= '0;
            cnt       <= 2'd0;
            rdata     <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (any_req) begin
                        sel <= win;
                        if (win == port_idx_t'(1)) begin
                            we_q      <= we1;
                            mem_addr  <= addr1;
                            mem_wdata <= wdata1;
                            mem_memop <= memop1;
                        end else begin
                            we_q      <= we0;
                            mem_addr  <= addr0;
                            mem_wdata <= wdata0;
                            mem_memop <= memop0;
                        end
                    end
                end
                ARB_ACCESS: begin
                    if (!we_q)
                        cnt <= 2'(RD_LAT - 1);
                end
                ARB_RDWAIT: begin
                    if (cnt == 2'd0) begin
                        rdata   <= mem_rdata;
                        rvalid0 <= (sel == port_idx_t'(0));
                        rvalid1 <= (sel == port_idx_t'(1));
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int RL  = 2;
    localparam int RDP = RL + 2;   // read issue-to-issue period

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic [2:0]    memop0 = '0, memop1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_memop;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .memop0    (memop0),
        .memop1    (memop1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_memop (mem_memop),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // data_mem stand-in: write commits on the edge closing ACCESS,
    // read data appears RL cycles after the address.
    logic [DW-1:0] mem_arr [0:63];
    logic [DW-1:0] rd_p1, rd_p2;
    initial for (int i = 0; i < 64; i++) mem_arr[i] = '0;
    always @(posedge clock) begin
        if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;
        rd_p1 <= mem_arr[mem_addr[7:2]];
        rd_p2 <= rd_p1;
    end
    assign mem_rdata = (RL == 1) ? rd_p1 : rd_p2;

    typedef struct {
        int            port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [2:0]    memop;
        int            cyc;
    } gnt_exp_t;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            cyc;
    } rv_exp_t;

    gnt_exp_t gq[$];
    rv_exp_t  rq[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cyc %0d)", name, cyc);
    endtask

    // Monitor: pops an expectation whenever the DUT presents gnt or rvalid.
    always @(negedge clock) begin
        gnt_exp_t g;
        rv_exp_t  r;
        if (reset_n) begin
            if (gnt0 && gnt1) fail("gnt_both_high");
            if (rvalid0 && rvalid1) fail("rvalid_both_high");
            if (mem_we && !(gnt0 || gnt1)) fail("mem_we_outside_access");
            if (gnt0 || gnt1) begin
                if (gq.size() == 0) fail("unexpected_gnt");
                else begin
                    g = gq.pop_front();
                    chk("gnt_port",  64'(gnt1),      64'(g.port));
                    chk("gnt_cycle", 64'(cyc),       64'(g.cyc));
                    chk("mem_we",    64'(mem_we),    64'(g.we));
                    chk("mem_addr",  64'(mem_addr),  64'(g.addr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(g.wdata));
                    chk("mem_memop", 64'(mem_memop), 64'(g.memop));
                end
            end
            if (rvalid0 || rvalid1) begin
                if (rq.size() == 0) fail("unexpected_rvalid");
                else begin
                    r = rq.pop_front();
                    chk("rvalid_port",  64'(rvalid1), 64'(r.port));
                    chk("rvalid_cycle", 64'(cyc),     64'(r.cyc));
                    chk("rdata",        64'(rdata),   64'(r.data));
                end
            end
        end
    end

    task automatic push_gnt(input int port, input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [2:0] op, input int c);
        gnt_exp_t g;
        g.port = port; g.we = we; g.addr = a; g.wdata = d; g.memop = op; g.cyc = c;
        gq.push_back(g);
    endtask

    task automatic push_rv(input int port, input logic [DW-1:0] d, input int c);
        rv_exp_t r;
        r.port = port; r.data = d; r.cyc = c;
        rq.push_back(r);
    endtask

    task automatic set_p0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] op);
        we0 = we; addr0 = a; wdata0 = d; memop0 = op;
    endtask

    task automatic set_p1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] op);
        we1 = we; addr1 = a; wdata1 = d; memop1 = op;
    endtask

    // Raise requests just after an edge; e is the index of the sampling edge,
    // which is also the cyc value seen while gnt is high.
    task automatic start_req(input logic r0, input logic r1, output int e);
        @(posedge clock); #1;
        req0 = r0;
        req1 = r1;
        e = cyc + 1;
    endtask

    task automatic wait_grants(input int n);
        int seen = 0;
        int t = 0;
        while (seen < n && t < 300) begin
            @(posedge clock); #1;
            t++;
            if (gnt0 || gnt1) seen++;
        end
        if (seen < n) fail("grant_timeout");
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((gq.size() != 0 || rq.size() != 0) && t < 60) begin
            @(posedge clock); #1;
            t++;
        end
        if (gq.size() != 0) fail("pending_gnt_timeout");
        if (rq.size() != 0) fail("pending_rvalid_timeout");
        repeat (4) @(posedge clock);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt0"},      64'(gnt0),      64'(0));
        chk({tag, "_gnt1"},      64'(gnt1),      64'(0));
        chk({tag, "_rvalid0"},   64'(rvalid0),   64'(0));
        chk({tag, "_rvalid1"},   64'(rvalid1),   64'(0));
        chk({tag, "_rdata"},     64'(rdata),     64'(0));
        chk({tag, "_mem_addr"},  64'(mem_addr),  64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
        chk({tag, "_mem_memop"}, 64'(mem_memop), 64'(0));
        chk({tag, "_mem_we"},    64'(mem_we),    64'(0));
    endtask

    // Both ports hold write requests until n grants have been issued.
    task automatic contend(input int n);
        int e;
        int p;
        set_p0(1'b1, 32'h0000_0020, 32'h1111_0000, 3'b010);
        set_p1(1'b1, 32'h0000_0024, 32'h2222_0000, 3'b001);
        start_req(1'b1, 1'b1, e);
        for (int k = 0; k < n; k++) begin
`ifdef DMEM_ARB_RR_EN
            p = k % 2;
`else
            p = 0;
`endif
            if (p == 0) push_gnt(0, 1'b1, 32'h0000_0020, 32'h1111_0000, 3'b010, e + 2 * k);
            else        push_gnt(1, 1'b1, 32'h0000_0024, 32'h2222_0000, 3'b001, e + 2 * k);
        end
        wait_grants(n);
        drain();
    endtask

    initial begin
        int e;

        repeat (3) @(posedge clock);
        #1;
        chk_outputs_zero("por");
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // Lone port-0 write.
        set_p0(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010);
        start_req(1'b1, 1'b0, e);
        push_gnt(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, e);
        wait_grants(1);
        drain();

        // Lone port-1 read of the word just written.
        set_p1(1'b0, 32'h0000_0010, 32'h0, 3'b010);
        start_req(1'b0, 1'b1, e);
        push_gnt(1, 1'b0, 32'h0000_0010, 32'h0, 3'b010, e);
        push_rv(1, 32'hDEAD_BEEF, e + 1 + RL);
        wait_grants(1);
        drain();

        // Continuous contention, six grants.
        contend(6);

        // Port-1 request raised during a port-0 read and withdrawn one cycle
        // before the arbiter returns to IDLE: never granted.
        set_p0(1'b0, 32'h0000_0020, 32'h0, 3'b000);
        start_req(1'b1, 1'b0, e);
        push_gnt(0, 1'b0, 32'h0000_0020, 32'h0, 3'b000, e);
        push_rv(0, 32'h1111_0000, e + 1 + RL);
        wait_grants(1);
        set_p1(1'b1, 32'h0000_0030, 32'h5555_AAAA, 3'b010);
        @(posedge clock); #1;
        req1 = 1'b1;
        repeat (RL - 1) @(posedge clock);
        #1;
        req1 = 1'b0;
        drain();
        chk("dropped_req_not_written", 64'(mem_arr[12]), 64'(0));

        // Reset asserted while a port-1 read sits in RDWAIT.
        set_p1(1'b0, 32'h0000_0010, 32'h0, 3'b010);
        start_req(1'b0, 1'b1, e);
        push_gnt(1, 1'b0, 32'h0000_0010, 32'h0, 3'b010, e);
        wait_grants(1);
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("midread_rst");
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (6) @(posedge clock);
        #1;

        // Pointer is back at its reset value: contention starts at port 0.
        contend(2);

        // Normal read after reset.
        set_p1(1'b0, 32'h0000_0010, 32'h0, 3'b010);
        start_req(1'b0, 1'b1, e);
        push_gnt(1, 1'b0, 32'h0000_0010, 32'h0, 3'b010, e);
        push_rv(1, 32'hDEAD_BEEF, e + 1 + RL);
        wait_grants(1);
        drain();

        // Back-to-back port-0 reads: one issue every RL+2 cycles.
        set_p0(1'b0, 32'h0000_0010, 32'h0, 3'b010);
        start_req(1'b1, 1'b0, e);
        for (int k = 0; k < 3; k++) begin
            push_gnt(0, 1'b0, 32'h0000_0010, 32'h0, 3'b010, e + k * RDP);
            push_rv(0, 32'hDEAD_BEEF, e + k * RDP + 1 + RL);
        end
        wait_grants(3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (cyc %0d)", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory port between the CPU load/store path (port 0) and a second bus master (port 1, e.g. video scan-out or a keyboard/DMA engine). It sits between the masters and `data_mem`, latches one request at a time, drives the memory address/data/memop/write-enable lines, and returns read data with a per-port valid pulse. Arbitration, access sequencing and read-latency tracking live here, so masters see a simple req/gnt/rvalid handshake.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `RD_LAT`, 1, memory read latency in cycles (1 or 2)

- `clock`  in  1  single system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  access request; must hold with stable payload until `gnt`
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_W  byte address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `memop0`, `memop1`  in  3  MemOp encoding, passed through unchanged
- `gnt0`, `gnt1`  out  1  one-cycle pulse: request accepted and issued
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse: `rdata` holds read result for that port
- `rdata`  out  DATA_W  read data, shared by both ports
- `mem_addr`  out  ADDR_W  to `data_mem.addr`
- `mem_wdata`  out  DATA_W  to `data_mem.datain`
- `mem_memop`  out  3  to `data_mem.memop`
- `mem_we`  out  1  to `data_mem.we`
- `mem_rdata`  in  DATA_W  from `data_mem.dataout`

## Operation
- FSM states: IDLE, ACCESS, RDWAIT.
- IDLE: sample `req0`/`req1`. None -> stay. One or both -> pick winner, latch its `we/addr/wdata/memop` into `mem_*` registers, go ACCESS.
- ACCESS (one cycle): `gnt<winner>`=1; `mem_we`=latched `we`. Write -> IDLE. Read -> RDWAIT, latency counter loaded with `RD_LAT`-1.
- RDWAIT: counter decrements; at 0, register `mem_rdata` into `rdata`, pulse `rvalid<winner>` next cycle, go IDLE.
- `mem_we` is high only in ACCESS for a write; 0 in every other state.
- Loser's request is ignored until next IDLE; it must keep `req` asserted.
- Withdrawing `req` before `gnt` is legal; only the IDLE sample matters.
- `rdata` holds last read value until next read completes.
- Reset values: state IDLE, all `gnt*`/`rvalid*` 0, `rdata` 0, `mem_addr`/`mem_wdata`/`mem_memop` 0, `mem_we` 0, RR pointer = port 1 last-served.
- Reset mid-read: transaction dropped, no `rvalid` after release.

## Timing
- Request sampled at edge N (IDLE) -> `gnt` and `mem_*` valid in cycle N+1.
- Write: memory commits in cycle N+1; arbiter back in IDLE at N+2; max one write per 2 cycles.
- Read: `rvalid`+`rdata` in cycle N+2+`RD_LAT`; next sample at that cycle.
- `gnt0` and `gnt1` never both high; `rvalid0` and `rvalid1` never both high.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin; on simultaneous requests the port not served last wins; pointer updates on each grant. First contention after reset goes to port 0.
- Undefined: fixed priority, port 0 (CPU) always wins; pointer logic absent. Port 1 may starve.

## Structure
- `dmem_arb_pkg`: state enum (`ARB_IDLE`, `ARB_ACCESS`, `ARB_RDWAIT`), `memop_t` (3-bit), port index type, `ARB_NPORTS`=2.
- Sub-module `rr_pick2`: combinational winner select from `req0/req1` and last-served pointer plus pointer register; compiled with or without `DMEM_ARB_RR_EN`.

## Test plan
- Port 0 write addr 0x0000_0010 data 0xDEAD_BEEF memop 3'b010 alone -> `gnt0` one cycle after sample, `mem_we`=1 for exactly one cycle with those values, no `rvalid`.
- Port 1 read addr 0x10, `RD_LAT`=1, memory returns 0xDEAD_BEEF -> `gnt1` at N+1, `rvalid1`=1 and `rdata`=0xDEAD_BEEF at N+3, `rvalid0` stays 0.
- Both ports request continuously, 6 grants, `DMEM_ARB_RR_EN` defined -> grant order 0,1,0,1,0,1; undefined -> 0,0,0,0,0,0.
- Port 1 drops `req1` one cycle before arbiter returns to IDLE while port 0 idle -> no `gnt1`, `mem_we` stays 0, FSM remains IDLE.
- `reset_n` asserted in RDWAIT with `RD_LAT`=2 -> all outputs 0 immediately, no `rvalid` after release, next request granted normally.
- `RD_LAT`=2, back-to-back reads from port 0 -> `rvalid0` spacing 4 cycles, `gnt0` never overlaps pending read.
